ahb_cmp_timer: RTL and testbench
================================

AHB_CMP_TIMER -- requirements
Module: ahb_cmp_timer

Interface
REQ-001 Parameter NCH, default 4, number of compare channels; legal range 1..8.
REQ-002 HCLK  input  1  clock; all state updates on rising edge.
REQ-003 HRESET  input  1  reset, asynchronous, active-high.
REQ-004 HSEL  input  1  slave select, data-phase aligned (address/write already delayed one cycle by the bus).
REQ-005 HADDR  input  [6:2]  word offset within the timer, data-phase aligned.
REQ-006 HWRITE  input  1  write strobe, data-phase aligned.
REQ-007 HWDATA  input  32  write data.
REQ-008 HRDATA  output  32  read data, combinational from HADDR and register state.
REQ-009 IRQ  output  1  interrupt, OR of enabled match flags, driven from registered state only.

Function
REQ-010 Word map: 0 CS, 1 CLO, 2 CHI, 3 CTRL, 4 IE, 8+n C[n], 16+n P[n], for n < NCH.
REQ-011 Unmapped offsets and offsets for n >= NCH read 0; writes to them are ignored.
REQ-012 A write occurs when HSEL & HWRITE; it takes effect at the next rising HCLK edge.
REQ-013 CTRL[0] EN (count enable), CTRL[15:8] PRESC; other CTRL bits read 0.
REQ-014 Prescaler: 8-bit PCNT counts 0..PRESC while EN; tick = EN & (PCNT == PRESC); PCNT wraps to 0 on tick.
REQ-015 EN=0: PCNT holds; no tick occurs.
REQ-016 A write to CTRL clears PCNT to 0.
REQ-017 Counter {CHI,CLO} is 64 bits; it increments by 1 on each tick, with carry from CLO into CHI; 2^64-1 wraps to 0.
REQ-018 A write to CLO or CHI in a tick cycle wins: that half loads HWDATA, and neither half increments that cycle.
REQ-019 Match event n: tick & (CLO+1 == C[n]), where CLO+1 wraps mod 2^32; i.e. the counter enters C[n]. Loading CLO never causes an event.
REQ-020 On event n, CS[n] is set to 1.
REQ-021 On event n with P[n] != 0, C[n] <= C[n] + P[n] mod 2^32 (periodic mode); with P[n] == 0, C[n] holds (one-shot).
REQ-022 A write to C[n] in the same cycle as event n wins: C[n] <= HWDATA, no reload; CS[n] is still set.
REQ-023 CS is write-1-to-clear on bits [NCH-1:0]; a write of 0 to a bit has no effect; bits >= NCH read 0.
REQ-024 An event and a W1C clear of the same bit in one cycle: set wins, and CS[n] = 1.
REQ-025 IE[NCH-1:0] is read/write; upper bits read 0.
REQ-026 IRQ = |(CS & IE), combinational from registers, no extra latency beyond CS/IE update.
REQ-027 Read latency 0: HRDATA reflects the register value before the current cycle's write.

Reset
REQ-028 HRESET=1 immediately forces: CLO=CHI=0, PCNT=0, CS=0, IE=0, all C[n]=0, all P[n]=0, CTRL=0x0000_0001 (EN=1, PRESC=0).
REQ-029 IRQ=0 during and immediately after reset.
REQ-030 HRDATA is combinational, so during reset it shows reset register values at the current HADDR.
REQ-031 Reset asserted mid-count or mid-write aborts that operation; no partial update survives.
REQ-032 The first tick after release occurs on the first HCLK edge with HRESET=0.

Verification
REQ-033 Reset release, no writes, 10 edges -> CLO=10, CHI=0, CS=0, IRQ=0.
REQ-034 Write CLO=0xFFFF_FFFE, CHI=5, then 3 edges -> CHI=6, CLO=1; a write to CLO concurrent with a tick -> CLO=HWDATA exactly.
REQ-035 C[0]=20, P[0]=0, IE=1 from counter 0 -> CS[0] and IRQ rise after edge 20. W1C CS=1 -> IRQ=0. No re-trigger until the counter wraps.
REQ-036 C[1]=10, P[1]=10 -> events at CLO=10,20,30, with C[1] reading 20,30,40. Write CS=2 in an event cycle -> CS[1] stays 1.
REQ-037 CTRL=0x0000_0301 (PRESC=3) -> CLO advances once per 4 edges. CTRL=0 -> CLO frozen; a read of CTRL returns 0.
REQ-038 NCH=2: write C[3] at offset 11 -> read 0. Read of offset 5 -> 0. Assert HRESET mid-count -> all REQ-028 values at once.

Source files
------------

// File: rtl/ahb_cmp_timer.sv
// AHB compare timer: 64-bit free-running counter with prescaler and NCH
// compare channels, each able to run one-shot or periodic, with
// write-1-to-clear status and a level interrupt.
module ahb_cmp_timer #(
    parameter int NCH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [6:2]  HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        IRQ
);

    localparam logic [4:0] A_CS   = 5'd0;
    localparam logic [4:0] A_CLO  = 5'd1;
    localparam logic [4:0] A_CHI  = 5'd2;
    localparam logic [4:0] A_CTRL = 5'd3;
    localparam logic [4:0] A_IE   = 5'd4;

    logic [31:0]    clo_r;
    logic [31:0]    chi_r;
    logic [7:0]     pcnt_r;
    logic           en_r;
    logic [7:0]     presc_r;
    logic [NCH-1:0] cs_r;
    logic [NCH-1:0] ie_r;
    logic [31:0]    cmp_r [NCH];
    logic [31:0]    per_r [NCH];

    logic           wr_s;
    logic           wr_cs_s;
    logic           wr_clo_s;
    logic           wr_chi_s;
    logic           wr_ctrl_s;
    logic           wr_ie_s;
    logic [NCH-1:0] wr_c_s;
    logic [NCH-1:0] wr_p_s;
    logic           tick_s;
    logic           adv_s;
    logic [31:0]    clo_inc_s;
    logic [NCH-1:0] evt_s;
    logic [NCH-1:0] cs_clr_s;
    logic [31:0]    rd_s;

    // Write decode, tick generation and per-channel match detection.
    always_comb begin
        wr_s      = HSEL & HWRITE;
        wr_cs_s   = wr_s & (HADDR == A_CS);
        wr_clo_s  = wr_s & (HADDR == A_CLO);
        wr_chi_s  = wr_s & (HADDR == A_CHI);
        wr_ctrl_s = wr_s & (HADDR == A_CTRL);
        wr_ie_s   = wr_s & (HADDR == A_IE);
        tick_s    = en_r & (pcnt_r == presc_r);
        // A counter load suppresses the increment, so it can never enter a compare value.
        adv_s     = tick_s & ~(wr_clo_s | wr_chi_s);
        clo_inc_s = clo_r + 32'd1;
        cs_clr_s  = wr_cs_s ? HWDATA[NCH-1:0] : {NCH{1'b0}};
        for (int n = 0; n < NCH; n++) begin
            wr_c_s[n] = wr_s & (HADDR == 5'(8 + n));
            wr_p_s[n] = wr_s & (HADDR == 5'(16 + n));
            evt_s[n]  = adv_s & (clo_inc_s == cmp_r[n]);
        end
    end

    // Control register: count enable and prescale value.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en_r    <= 1'b1;
            presc_r <= 8'd0;
        end else if (wr_ctrl_s) begin
            en_r    <= HWDATA[0];
            presc_r <= HWDATA[15:8];
        end else begin
            en_r    <= en_r;
            presc_r <= presc_r;
        end
    end

    // Prescaler: restarts on CTRL write, wraps on tick, holds while disabled.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pcnt_r <= 8'd0;
        end else if (wr_ctrl_s || tick_s) begin
            pcnt_r <= 8'd0;
        end else if (en_r) begin
            pcnt_r <= pcnt_r + 8'd1;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // 64-bit counter: a bus load of either half takes priority over the tick.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            clo_r <= 32'd0;
            chi_r <= 32'd0;
        end else if (wr_clo_s) begin
            clo_r <= HWDATA;
        end else if (wr_chi_s) begin
            chi_r <= HWDATA;
        end else if (tick_s) begin
            clo_r <= clo_inc_s;
            chi_r <= chi_r + {31'd0, (clo_r == 32'hFFFF_FFFF)};
        end else begin
            clo_r <= clo_r;
            chi_r <= chi_r;
        end
    end

    // Compare and period registers; periodic channels advance their compare on match.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int n = 0; n < NCH; n++) begin
                cmp_r[n] <= 32'd0;
                per_r[n] <= 32'd0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (wr_c_s[n]) begin
                    cmp_r[n] <= HWDATA;
                end else if (evt_s[n] && (per_r[n] != 32'd0)) begin
                    cmp_r[n] <= cmp_r[n] + per_r[n];
                end else begin
                    cmp_r[n] <= cmp_r[n];
                end
                per_r[n] <= wr_p_s[n] ? HWDATA : per_r[n];
            end
        end
    end

    // Status (match set beats W1C clear) and interrupt enable.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cs_r <= {NCH{1'b0}};
            ie_r <= {NCH{1'b0}};
        end else begin
            cs_r <= (cs_r & ~cs_clr_s) | evt_s;
            ie_r <= wr_ie_s ? HWDATA[NCH-1:0] : ie_r;
        end
    end

    // Zero-latency read mux; unmapped and absent-channel offsets read zero.
    always_comb begin
        rd_s = 32'd0;
        case (HADDR)
            A_CS:    rd_s = 32'(cs_r);
            A_CLO:   rd_s = clo_r;
            A_CHI:   rd_s = chi_r;
            A_CTRL:  rd_s = {16'd0, presc_r, 7'd0, en_r};
            A_IE:    rd_s = 32'(ie_r);
            default: begin
                for (int n = 0; n < NCH; n++) begin
                    rd_s = (HADDR == 5'(8 + n))  ? cmp_r[n] :
                           (HADDR == 5'(16 + n)) ? per_r[n] : rd_s;
                end
            end
        endcase
    end

    assign HRDATA = rd_s;
    assign IRQ    = |(cs_r & ie_r);

endmodule

// File: tb/tb_ahb_cmp_timer.sv
// Self-checking bench for ahb_cmp_timer (NCH=2) against a behavioural model.
module tb_ahb_cmp_timer;

    localparam int NCH = 2;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [6:2]  HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        IRQ;

    int checks;
    int errors;

    // Behavioural model state
    logic [63:0]    m_cnt;
    logic [7:0]     m_pcnt;
    logic [7:0]     m_presc;
    logic           m_en;
    logic [NCH-1:0] m_cs;
    logic [NCH-1:0] m_ie;
    logic [31:0]    m_c [NCH];
    logic [31:0]    m_p [NCH];

    logic [4:0] addr_tbl [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8,
                                  5'd9, 5'd16, 5'd17, 5'd10, 5'd5, 5'd18};

    ahb_cmp_timer #(.NCH(NCH)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .HSEL   (HSEL),
        .HADDR  (HADDR),
        .HWRITE (HWRITE),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .IRQ    (IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic void m_reset();
        m_cnt   = 64'd0;
        m_pcnt  = 8'd0;
        m_presc = 8'd0;
        m_en    = 1'b1;
        m_cs    = '0;
        m_ie    = '0;
        for (int n = 0; n < NCH; n++) begin
            m_c[n] = 32'd0;
            m_p[n] = 32'd0;
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int idx;
        idx = int'(a);
        if (idx == 0) return 32'(m_cs);
        if (idx == 1) return m_cnt[31:0];
        if (idx == 2) return m_cnt[63:32];
        if (idx == 3) return {16'd0, m_presc, 7'd0, m_en};
        if (idx == 4) return 32'(m_ie);
        if (idx >= 8 && idx < 8 + NCH) return m_c[idx - 8];
        if (idx >= 16 && idx < 16 + NCH) return m_p[idx - 16];
        return 32'd0;
    endfunction

    function automatic logic m_irq();
        return |(m_cs & m_ie);
    endfunction

    // One clock edge of the model, given this cycle's bus write (if any).
    function automatic void m_apply(input logic wr, input logic [4:0] a, input logic [31:0] d);
        logic           tick;
        logic           adv;
        logic [63:0]    nc;
        logic [NCH-1:0] ev;
        logic [NCH-1:0] clr;
        tick = m_en && (m_pcnt == m_presc);
        adv  = tick && !(wr && (a == 5'd1 || a == 5'd2));
        nc   = adv ? m_cnt + 64'd1 : m_cnt;
        if (wr && a == 5'd1) nc[31:0]  = d;
        if (wr && a == 5'd2) nc[63:32] = d;
        for (int n = 0; n < NCH; n++) ev[n] = adv && (nc[31:0] == m_c[n]);
        if (wr && a == 5'd3) m_pcnt = 8'd0;
        else if (tick) m_pcnt = 8'd0;
        else if (m_en) m_pcnt = m_pcnt + 8'd1;
        if (wr && a == 5'd3) begin
            m_en    = d[0];
            m_presc = d[15:8];
        end
        m_cnt = nc;
        clr  = (wr && a == 5'd0) ? d[NCH-1:0] : '0;
        m_cs = (m_cs & ~clr) | ev;
        if (wr && a == 5'd4) m_ie = d[NCH-1:0];
        for (int n = 0; n < NCH; n++) begin
            if (wr && a == 5'(8 + n)) m_c[n] = d;
            else if (ev[n] && m_p[n] != 32'd0) m_c[n] = m_c[n] + m_p[n];
            if (wr && a == 5'(16 + n)) m_p[n] = d;
        end
    endfunction

    // One bus cycle; HRDATA and IRQ are checked against the model before the edge.
    task automatic cycle(input logic wr, input logic [4:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = wr; HWRITE = wr; HADDR = a; HWDATA = d;
        #1;
        checks++;
        if (HRDATA !== m_read(a)) begin
            errors++;
            $display("FAIL model_rd addr=%0d got=%h exp=%h t=%0t", a, HRDATA, m_read(a), $time);
        end
        checks++;
        if (IRQ !== m_irq()) begin
            errors++;
            $display("FAIL model_irq got=%b exp=%b t=%0t", IRQ, m_irq(), $time);
        end
        m_apply(wr, a, d);
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HWRITE = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd1, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b1, a, d);
    endtask

    // Read cycle with a fixed expected value (and optional fixed IRQ level).
    task automatic expect_rd(input logic [4:0] a, input logic [31:0] exp, input int exp_irq, input string nm);
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0; HADDR = a;
        #1;
        checks++;
        if (HRDATA !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=%h exp=%h", nm, a, HRDATA, exp);
        end
        if (exp_irq >= 0) begin
            checks++;
            if (IRQ !== exp_irq[0]) begin
                errors++;
                $display("FAIL %s_irq got=%b exp=%b", nm, IRQ, exp_irq[0]);
            end
        end
        checks++;
        if (HRDATA !== m_read(a) || IRQ !== m_irq()) begin
            errors++;
            $display("FAIL %s_model rd=%h exp=%h irq=%b exp=%b", nm, HRDATA, m_read(a), IRQ, m_irq());
        end
        m_apply(1'b0, a, 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset(input logic mid_write);
        @(negedge HCLK);
        HSEL = mid_write; HWRITE = mid_write; HADDR = 5'd1; HWDATA = 32'h1234_5678;
        #2;
        HRESET = 1'b1;
        #1;
        HSEL = 1'b0; HWRITE = 1'b0;
        m_reset();
        for (int a = 0; a < 24; a++) begin
            HADDR = 5'(a);
            #1;
            checks++;
            if (HRDATA !== ((a == 3) ? 32'd1 : 32'd0)) begin
                errors++;
                $display("FAIL reset_rd addr=%0d got=%h exp=%h", a, HRDATA, (a == 3) ? 32'd1 : 32'd0);
            end
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL reset_irq got=%b exp=0", IRQ);
            end
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        idle(10);
        expect_rd(5'd1, 32'd10, 0, "run10_clo");
        expect_rd(5'd2, 32'd0, 0, "run10_chi");
        expect_rd(5'd0, 32'd0, 0, "run10_cs");
    endtask

    task automatic test_carry();
        wr(5'd3, 32'd1);
        wr(5'd4, 32'd0);
        wr(5'd1, 32'hFFFF_FFFE);
        wr(5'd2, 32'd5);
        idle(3);
        expect_rd(5'd1, 32'd1, 0, "carry_clo");
        expect_rd(5'd2, 32'd6, 0, "carry_chi");
        begin
            logic [31:0] r;
            r = $urandom;
            wr(5'd1, r);
            expect_rd(5'd1, r, 0, "load_in_tick");
        end
    endtask

    task automatic test_oneshot();
        wr(5'd3, 32'd1);
        wr(5'd9, 32'hFFFF_0000);
        wr(5'd8, 32'd20);
        wr(5'd16, 32'd0);
        wr(5'd4, 32'd1);
        wr(5'd2, 32'd0);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'd3);
        idle(18);
        expect_rd(5'd0, 32'd0, 0, "oneshot_before");
        expect_rd(5'd0, 32'd1, 1, "oneshot_hit");
        wr(5'd0, 32'd1);
        expect_rd(5'd0, 32'd0, 0, "oneshot_w1c");
        idle(40);
        expect_rd(5'd0, 32'd0, 0, "oneshot_noretrig");
        expect_rd(5'd8, 32'd20, 0, "oneshot_hold");
    endtask

    task automatic test_periodic();
        wr(5'd8, 32'hFFFF_0000);
        wr(5'd9, 32'd10);
        wr(5'd17, 32'd10);
        wr(5'd4, 32'd2);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'd3);
        idle(8);
        expect_rd(5'd9, 32'd10, 0, "per_c1_pre");
        expect_rd(5'd9, 32'd20, 1, "per_c1_10");
        expect_rd(5'd0, 32'd2, 1, "per_cs_10");
        idle(7);
        wr(5'd0, 32'd2);
        expect_rd(5'd0, 32'd2, 1, "per_set_wins");
        expect_rd(5'd9, 32'd30, 1, "per_c1_20");
        idle(7);
        expect_rd(5'd9, 32'd30, 1, "per_c1_pre30");
        expect_rd(5'd9, 32'd40, 1, "per_c1_30");
        wr(5'd4, 32'd0);
    endtask

    task automatic test_presc();
        wr(5'd3, 32'h0000_0301);
        wr(5'd1, 32'd0);
        idle(6);
        expect_rd(5'd1, 32'd1, -1, "presc_a");
        expect_rd(5'd1, 32'd2, -1, "presc_b");
        idle(2);
        expect_rd(5'd1, 32'd2, -1, "presc_c");
        expect_rd(5'd1, 32'd3, -1, "presc_d");
        wr(5'd3, 32'd0);
        expect_rd(5'd3, 32'd0, -1, "ctrl_zero");
        idle(5);
        expect_rd(5'd1, 32'd3, -1, "frozen");
        wr(5'd3, 32'd1);
    endtask

    task automatic test_unmapped();
        wr(5'd11, 32'hDEAD_BEEF);
        expect_rd(5'd11, 32'd0, -1, "c3_absent");
        wr(5'd5, 32'hFFFF_FFFF);
        expect_rd(5'd5, 32'd0, -1, "off5");
        expect_rd(5'd19, 32'd0, -1, "p3_absent");
        wr(5'd3, 32'hFFFF_FFFF);
        expect_rd(5'd3, 32'h0000_FF01, -1, "ctrl_mask");
        wr(5'd4, 32'hFFFF_FFFF);
        expect_rd(5'd4, 32'd3, -1, "ie_mask");
        wr(5'd3, 32'd1);
        wr(5'd4, 32'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic        w;
            a = addr_tbl[$urandom_range(0, 11)];
            w = ($urandom_range(0, 9) < 3);
            d = $urandom;
            if (a == 5'd3) d = {16'd0, 6'd0, 2'($urandom_range(0, 3)), 7'd0, ($urandom_range(0, 7) != 0)};
            if (a == 5'd8 || a == 5'd9) d = m_cnt[31:0] + 32'($urandom_range(1, 8));
            if (a == 5'd16 || a == 5'd17) d = 32'($urandom_range(0, 6));
            cycle(w, a, d);
        end
    endtask

    task automatic test_reset_mid();
        wr(5'd3, 32'd1);
        idle(5);
        apply_reset(1'b1);
        idle(3);
        expect_rd(5'd1, 32'd3, 0, "post_reset_clo");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HADDR  = 5'd0;
        HWDATA = 32'd0;
        m_reset();
        test_reset();
        test_carry();
        test_oneshot();
        test_periodic();
        test_presc();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
